// File: rtl/gerenciador_de_entradas.sv
// gerenciador_de_entradas: keypad/switch decimal entry for the board I/O path.
// Debounces three raw keys, collects up to NUM_DIGITS BCD digits, converts
// them MSB-first into a binary value and hands it over with a valid/ack
// handshake.
// Optional build macro ENTRADA_SINAL_EN adds a sign switch (sinal_in) that
// makes valor the two's complement of the converted magnitude.

module debounce_tecla #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tecla_n,
    output logic o_pulso
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          r_sync1, r_sync2, r_estavel, r_pulso;
    logic [CW-1:0] r_cnt;

    // Synchronize the raw key, then accept a new level only after it has
    // differed from the stable level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_estavel <= 1'b1;
            r_cnt     <= '0;
            r_pulso   <= 1'b0;
        end else begin
            r_sync1 <= i_tecla_n;
            r_sync2 <= r_sync1;
            r_pulso <= 1'b0;
            if (r_sync2 == r_estavel) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_estavel <= r_sync2;
                r_cnt     <= '0;
                r_pulso   <= ~r_sync2;   // only press (high->low) is reported
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_pulso = r_pulso;
endmodule

module gerenciador_de_entradas #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int NUM_DIGITS      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  digito_in,
    input  logic        key_digito_n,
    input  logic        key_enter_n,
    input  logic        key_limpa_n,
    input  logic        rd_ack,
`ifdef ENTRADA_SINAL_EN
    input  logic        sinal_in,
`endif
    output logic [31:0] valor,
    output logic        valor_valido,
    output logic [31:0] digitos_bcd,
    output logic [3:0]  num_digitos,
    output logic        erro
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_VALID   = 2'd2;

    logic [2:0]  w_teclas_n, w_pulsos;
    logic        w_digito, w_enter, w_limpa;
    logic [3:0]  w_nibble;
    logic [26:0] w_acc_prox;
    logic [31:0] w_resultado, w_valor_final;

    logic [1:0]  r_estado;
    logic [31:0] r_bcd, r_valor;
    logic [3:0]  r_num;
    logic [26:0] r_acc;
    logic [2:0]  r_idx;
    logic        r_valido, r_erro;
`ifdef ENTRADA_SINAL_EN
    logic        r_sinal;
`endif

    assign w_teclas_n = {key_limpa_n, key_enter_n, key_digito_n};

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_deb
            debounce_tecla #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_tecla_n (w_teclas_n[g]),
                .o_pulso   (w_pulsos[g])
            );
        end
    endgenerate

    assign w_digito = w_pulsos[0];
    assign w_enter  = w_pulsos[1];
    assign w_limpa  = w_pulsos[2];

    // acc*10 + nibble; 27 bits hold 99,999,999 so this never wraps.
    assign w_nibble    = r_bcd[{r_idx, 2'b00} +: 4];
    assign w_acc_prox  = (r_acc << 3) + (r_acc << 1) + {23'd0, w_nibble};
    assign w_resultado = {5'd0, w_acc_prox};
`ifdef ENTRADA_SINAL_EN
    assign w_valor_final = r_sinal ? (~w_resultado + 32'd1) : w_resultado;
`else
    assign w_valor_final = w_resultado;
`endif

    // Entry/convert/handshake FSM; clear overrides everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= S_IDLE;
            r_bcd    <= '0;
            r_num    <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_valor  <= '0;
            r_valido <= 1'b0;
            r_erro   <= 1'b0;
`ifdef ENTRADA_SINAL_EN
            r_sinal  <= 1'b0;
`endif
        end else if (w_limpa) begin
            r_estado <= S_IDLE;
            r_bcd    <= '0;
            r_num    <= '0;
            r_valido <= 1'b0;
            r_erro   <= 1'b0;
        end else begin
            case (r_estado)
                S_IDLE: begin
                    if (w_enter) begin
                        r_acc <= '0;
                        r_idx <= 3'(r_num - 4'd1);
`ifdef ENTRADA_SINAL_EN
                        r_sinal <= sinal_in;
`endif
                        if (r_num == 4'd0) begin
                            r_valor  <= '0;
                            r_valido <= 1'b1;
                            r_estado <= S_VALID;
                        end else begin
                            r_estado <= S_CONVERT;
                        end
                    end else if (w_digito) begin
                        if (digito_in > 4'd9 || r_num == 4'(NUM_DIGITS)) begin
                            r_erro <= 1'b1;
                        end else begin
                            r_bcd <= {r_bcd[27:0], digito_in};
                            r_num <= r_num + 4'd1;
                        end
                    end
                end
                S_CONVERT: begin
                    if (r_idx == 3'd0) begin
                        r_valor  <= w_valor_final;
                        r_valido <= 1'b1;
                        r_estado <= S_VALID;
                    end else begin
                        r_acc <= w_acc_prox;
                        r_idx <= r_idx - 3'd1;
                    end
                end
                S_VALID: begin
                    if (rd_ack) begin
                        r_valido <= 1'b0;
                        r_bcd    <= '0;
                        r_num    <= '0;
                        r_estado <= S_IDLE;
                    end
                end
                default: r_estado <= S_IDLE;
            endcase
        end
    end

    assign valor        = r_valor;
    assign valor_valido = r_valido;
    assign digitos_bcd  = r_bcd;
    assign num_digitos  = r_num;
    assign erro         = r_erro;
endmodule

// File: tb/tb_gerenciador_de_entradas.sv
// Bench for gerenciador_de_entradas (DEBOUNCE_CYCLES=4, NUM_DIGITS=8).
// A queue-based model of the typed entry predicts every observable output.
module tb_gerenciador_de_entradas;
    localparam int DEB = 4;
    localparam int ND  = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [3:0]  digito_in = 4'd0;
    logic        key_digito_n = 1'b1, key_enter_n = 1'b1, key_limpa_n = 1'b1, rd_ack = 1'b0;
    logic [31:0] valor, digitos_bcd;
    logic        valor_valido, erro;
    logic [3:0]  num_digitos;
    logic        sinal_cur = 1'b0;
`ifdef ENTRADA_SINAL_EN
    logic        sinal_in;
    assign sinal_in = sinal_cur;
`endif

    gerenciador_de_entradas #(.DEBOUNCE_CYCLES(DEB), .NUM_DIGITS(ND)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .digito_in    (digito_in),
        .key_digito_n (key_digito_n),
        .key_enter_n  (key_enter_n),
        .key_limpa_n  (key_limpa_n),
        .rd_ack       (rd_ack),
`ifdef ENTRADA_SINAL_EN
        .sinal_in     (sinal_in),
`endif
        .valor        (valor),
        .valor_valido (valor_valido),
        .digitos_bcd  (digitos_bcd),
        .num_digitos  (num_digitos),
        .erro         (erro)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int lat_dig, lat_vld, L;

    // reference model: typed digits in order, plus result/flags
    int          m_dig[$];
    bit          m_erro = 0, m_valid = 0;
    logic [31:0] m_valor = 0;

    logic [69:0] obs;
    assign obs = {digitos_bcd, num_digitos, valor, valor_valido, erro};

    function automatic logic [69:0] model_vec();
        logic [31:0] b;
        b = 32'd0;
        foreach (m_dig[i]) b = {b[27:0], 4'(m_dig[i])};
        return {b, 4'(m_dig.size()), m_valor, m_valid, m_erro};
    endfunction

    function automatic void m_push(int d);
        if (!m_valid) begin
            if (d > 9 || m_dig.size() == ND) m_erro = 1;
            else m_dig.push_back(d);
        end
    endfunction

    function automatic void m_enter(bit neg);
        longint v;
        v = 0;
        if (!m_valid) begin
            foreach (m_dig[i]) v = v * 10 + m_dig[i];
            if (neg) v = -v;
            m_valor = 32'(v);
            m_valid = 1;
        end
    endfunction

    function automatic void m_ack();
        if (m_valid) begin
            m_valid = 0;
            m_dig.delete();
        end
    endfunction

    function automatic void m_clear();
        m_dig.delete();
        m_valid = 0;
        m_erro  = 0;
    endfunction

    // Hold key sel (0 digit, 1 enter, 2 clear) low for hold cycles, observe 40 cycles.
    task automatic press(input int sel, input int hold);
        logic [3:0] n0;
        logic       v0;
        n0 = num_digitos;
        v0 = valor_valido;
        lat_dig = -1;
        lat_vld = -1;
        @(negedge clk);
        if (sel == 0) key_digito_n = 1'b0;
        else if (sel == 1) key_enter_n = 1'b0;
        else key_limpa_n = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (lat_dig < 0 && num_digitos !== n0) lat_dig = c;
            if (lat_vld < 0 && valor_valido === 1'b1 && v0 === 1'b0) lat_vld = c;
            if (c == hold) begin
                key_digito_n = 1'b1;
                key_enter_n  = 1'b1;
                key_limpa_n  = 1'b1;
            end
        end
    endtask

    task automatic push(input int d);
        digito_in = 4'(d);
        press(0, 10);
        m_push(d);
    endtask

    task automatic enter();
        press(1, 10);
        m_enter(sinal_cur);
    endtask

    task automatic clear();
        press(2, 10);
        m_clear();
    endtask

    task automatic ack();
        @(negedge clk); rd_ack = 1'b1;
        @(negedge clk); rd_ack = 1'b0;
        repeat (2) @(negedge clk);
        m_ack();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        if (obs !== 70'd0) begin failures++; $display("FAIL reset_hold got=%h exp=0", obs); end
        checks++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        if (obs !== model_vec()) begin failures++; $display("FAIL reset_release got=%h exp=%h", obs, model_vec()); end
        checks++;
    endtask

    task automatic test_debounce();
        digito_in = 4'd7;
        @(negedge clk); key_digito_n = 1'b0;
        repeat (2) @(negedge clk); key_digito_n = 1'b1;
        repeat (20) @(negedge clk);
        if (obs !== model_vec()) begin failures++; $display("FAIL glitch got=%h exp=%h", obs, model_vec()); end
        checks++;
        push(7);
        L = lat_dig;
        if (obs !== model_vec()) begin failures++; $display("FAIL single_push got=%h exp=%h", obs, model_vec()); end
        checks++;
        if (L < DEB || L > DEB + 4) begin failures++; $display("FAIL debounce_latency got=%0d exp=%0d..%0d", L, DEB, DEB + 4); end
        checks++;
        clear();
    endtask

    task automatic test_basic();
        push(1); push(2); push(3);
        if (obs !== model_vec()) begin failures++; $display("FAIL basic_entry got=%h exp=%h", obs, model_vec()); end
        checks++;
        enter();
        if (lat_vld !== L + 3) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat_vld, L + 3); end
        checks++;
        if (valor !== 32'd123 || obs !== model_vec()) begin failures++; $display("FAIL basic_value got=%h exp=%h", obs, model_vec()); end
        checks++;
        ack();
        if (obs !== model_vec()) begin failures++; $display("FAIL basic_ack got=%h exp=%h", obs, model_vec()); end
        checks++;
    endtask

    task automatic test_overflow();
        repeat (8) push(9);
        push(5);
        if (erro !== 1'b1 || obs !== model_vec()) begin failures++; $display("FAIL overflow_push got=%h exp=%h", obs, model_vec()); end
        checks++;
        enter();
        if (valor !== 32'h05F5E0FF || obs !== model_vec()) begin failures++; $display("FAIL overflow_value got=%h exp=%h", obs, model_vec()); end
        checks++;
        ack();
        clear();
    endtask

    task automatic test_invalid();
        push(3);
        push(10);
        if (obs !== model_vec()) begin failures++; $display("FAIL invalid_digit got=%h exp=%h", obs, model_vec()); end
        checks++;
        clear();
        if (obs !== model_vec()) begin failures++; $display("FAIL invalid_clear got=%h exp=%h", obs, model_vec()); end
        checks++;
    endtask

    task automatic test_valid_ignore();
        push(2); push(11); push(6);
        enter();
        push(5);
        enter();
        if (obs !== model_vec()) begin failures++; $display("FAIL valid_ignore got=%h exp=%h", obs, model_vec()); end
        checks++;
        // clear pulse and rd_ack land on the same edge
        @(negedge clk); key_limpa_n = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == L - 1) rd_ack = 1'b1;
            if (c == L) rd_ack = 1'b0;
            if (c == 10) key_limpa_n = 1'b1;
        end
        m_clear();
        if (erro !== 1'b0 || obs !== model_vec()) begin failures++; $display("FAIL clear_vs_ack got=%h exp=%h", obs, model_vec()); end
        checks++;
    endtask

    task automatic test_zero_enter();
        enter();
        if (lat_vld !== L) begin failures++; $display("FAIL zero_latency got=%0d exp=%0d", lat_vld, L); end
        checks++;
        if (valor !== 32'd0 || obs !== model_vec()) begin failures++; $display("FAIL zero_value got=%h exp=%h", obs, model_vec()); end
        checks++;
        ack();
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int n;
            n = $urandom_range(1, ND + 1);
            for (int k = 0; k < n; k++)
                push(($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9));
            if (obs !== model_vec()) begin failures++; $display("FAIL rand_entry it=%0d got=%h exp=%h", it, obs, model_vec()); end
            checks++;
            enter();
            if (obs !== model_vec()) begin failures++; $display("FAIL rand_value it=%0d got=%h exp=%h", it, obs, model_vec()); end
            checks++;
            ack();
            if (obs !== model_vec()) begin failures++; $display("FAIL rand_ack it=%0d got=%h exp=%h", it, obs, model_vec()); end
            checks++;
            if ($urandom_range(0, 1) == 1) clear();
        end
    endtask

    task automatic test_reset_mid_convert();
        clear();
        for (int k = 0; k < ND; k++) push($urandom_range(1, 9));
        @(negedge clk); key_enter_n = 1'b0;
        for (int c = 1; c <= L + 3; c++) begin
            @(posedge clk); #1;
        end
        if (valor_valido !== 1'b0) begin failures++; $display("FAIL mid_convert_state got=%b exp=0", valor_valido); end
        checks++;
        rst_n = 1'b0;
        #1;
        if (obs !== 70'd0) begin failures++; $display("FAIL mid_convert_reset got=%h exp=0", obs); end
        checks++;
        key_enter_n = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        m_clear();
        m_valor = 32'd0;
        repeat (20) @(negedge clk);
        if (obs !== model_vec()) begin failures++; $display("FAIL after_reset got=%h exp=%h", obs, model_vec()); end
        checks++;
    endtask

`ifdef ENTRADA_SINAL_EN
    task automatic test_sign();
        clear();
        sinal_cur = 1'b1;
        push(4); push(2);
        enter();
        if (valor !== 32'hFFFFFFD6 || obs !== model_vec()) begin failures++; $display("FAIL sign_value got=%h exp=%h", obs, model_vec()); end
        checks++;
        ack();
        sinal_cur = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_debounce();
        test_basic();
        test_overflow();
        test_invalid();
        test_valid_ignore();
        test_zero_enter();
        test_random();
`ifdef ENTRADA_SINAL_EN
        test_sign();
`endif
        test_reset_mid_convert();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
